// File: rtl/sap_controller_sequencer_pkg.sv
// Shared constants for the SAP-1 controller-sequencer: opcodes, control-word
// bit positions and the one-hot T-state encoding.
package sap_pkg;

    localparam int T_STATES = 6;
    localparam int OPCODE_W = 4;
    localparam int CW_W     = 13;

    localparam int CW_JP = 12;
    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    typedef logic [OPCODE_W-1:0] opcode_t;
    typedef logic [CW_W-1:0]     cw_t;

    localparam opcode_t OP_LDA = 4'b0000;
    localparam opcode_t OP_ADD = 4'b0001;
    localparam opcode_t OP_SUB = 4'b0010;
    localparam opcode_t OP_JMP = 4'b0011;
    localparam opcode_t OP_OUT = 4'b1110;
    localparam opcode_t OP_HLT = 4'b1111;

    // T_IDLE (all zero) is the frozen ring while halted.
    typedef enum logic [T_STATES-1:0] {
        T_IDLE = 6'b000000,
        T1     = 6'b000001,
        T2     = 6'b000010,
        T3     = 6'b000100,
        T4     = 6'b001000,
        T5     = 6'b010000,
        T6     = 6'b100000
    } t_state_e;

endpackage

// File: rtl/sap_controller_sequencer_if.sv
// Control interface between the sequencer (master) and the SAP-1 datapath (slave).
interface sap_controller_sequencer_if;
    import sap_pkg::*;

    logic [OPCODE_W-1:0] opcode;
    logic [T_STATES-1:0] t_state;
    logic [CW_W-1:0]     con;
    logic                halted;

    modport master (input opcode, output t_state, output con, output halted);
    modport slave  (output opcode, input t_state, input con, input halted);

endinterface

// File: rtl/sap_controller_sequencer_ring_counter.sv
// One-hot T-state ring: rotates T1..T6, collapses to all-zero on halt,
// and returns to T1 on a synchronous active-low clear.
module sap_ring_counter
    import sap_pkg::*;
(
    input  logic                clk,
    input  logic                clear,
    input  logic                halt,
    output logic [T_STATES-1:0] t_state
);

    t_state_e state_q;
    t_state_e state_d;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (halt) begin
            state_d = T_IDLE;
        end else begin
            state_d = t_state_e'({state_q[T_STATES-2:0], state_q[T_STATES-1]});
        end
    end

    assign t_state = state_q;

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP-1 controller-sequencer: ring counter, sticky halt flag and control-word
// decode. Define SAP_JUMP_EN to decode JMP (4'b0011).
module sap_controller_sequencer
    import sap_pkg::*;
(
    input  logic                       clk,
    input  logic                       clear,
    sap_controller_sequencer_if.master bus
);

    logic halted_q;
    logic halted_d;
    logic halt;
    cw_t  con_d;
    logic [T_STATES-1:0] t_state;

    // HLT is recognised in T4; the edge ending T4 freezes the ring at zero.
    assign halt     = halted_q | ((t_state == T4) && (bus.opcode == OP_HLT));
    assign halted_d = halt;

    always_ff @(posedge clk) begin
        if (!clear) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    sap_ring_counter u_ring (
        .clk     (clk),
        .clear   (clear),
        .halt    (halt),
        .t_state (t_state)
    );

    // NOTE: con_d is zeroed before the case so every path assigns it and no
    // latch is inferred.
    always_comb begin
        con_d = '0;
        case (t_state)
            T1: begin
                con_d[CW_EP] = 1'b1;
                con_d[CW_LM] = 1'b1;
            end
            T2: con_d[CW_CP] = 1'b1;
            T3: begin
                con_d[CW_CE] = 1'b1;
                con_d[CW_LI] = 1'b1;
            end
            T4: begin
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        con_d[CW_EI] = 1'b1;
                        con_d[CW_LM] = 1'b1;
                    end
                    OP_OUT: begin
                        con_d[CW_EA] = 1'b1;
                        con_d[CW_LO] = 1'b1;
                    end
`ifdef SAP_JUMP_EN
                    OP_JMP: begin
                        con_d[CW_EI] = 1'b1;
                        con_d[CW_JP] = 1'b1;
                    end
`endif
                    default: con_d = '0;
                endcase
            end
            T5: begin
                case (bus.opcode)
                    OP_LDA: begin
                        con_d[CW_CE] = 1'b1;
                        con_d[CW_LA] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        con_d[CW_CE] = 1'b1;
                        con_d[CW_LB] = 1'b1;
                    end
                    default: con_d = '0;
                endcase
            end
            T6: begin
                case (bus.opcode)
                    OP_ADD: begin
                        con_d[CW_EU] = 1'b1;
                        con_d[CW_LA] = 1'b1;
                    end
                    OP_SUB: begin
                        con_d[CW_SU] = 1'b1;
                        con_d[CW_EU] = 1'b1;
                        con_d[CW_LA] = 1'b1;
                    end
                    default: con_d = '0;
                endcase
            end
            default: con_d = '0;
        endcase
`ifndef SAP_JUMP_EN
        con_d[CW_JP] = 1'b0;
`endif
    end

    assign bus.con     = con_d;
    assign bus.t_state = t_state;
    assign bus.halted  = halted_q;

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Self-checking bench: directed test-plan steps then randomized opcode/clear
// traffic, compared against an instruction-step reference model.
module tb_sap_controller_sequencer;

    logic clk;
    logic clear;

    int vectors;
    int miscompares;

    // Reference model: step number 1..6 and halt flag.
    int   m_step;
    logic m_halted;

    localparam logic [15:0] B_JP = 16'h1000, B_CP = 16'h0800, B_EP = 16'h0400,
                            B_LM = 16'h0200, B_CE = 16'h0100, B_LI = 16'h0080,
                            B_EI = 16'h0040, B_LA = 16'h0020, B_EA = 16'h0010,
                            B_SU = 16'h0008, B_EU = 16'h0004, B_LB = 16'h0002,
                            B_LO = 16'h0001;

    sap_controller_sequencer_if bus ();

    sap_controller_sequencer dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] exp_con(input logic [3:0] op, input int step, input logic hlt);
        logic [15:0] c;
        c = 16'h0;
        if (!hlt) begin
            if (step == 1) c = B_EP | B_LM;
            else if (step == 2) c = B_CP;
            else if (step == 3) c = B_CE | B_LI;
            else begin
                case (op)
                    4'b0000: c = (step == 4) ? (B_EI | B_LM) : (step == 5) ? (B_CE | B_LA) : 16'h0;
                    4'b0001: c = (step == 4) ? (B_EI | B_LM) : (step == 5) ? (B_CE | B_LB) : (B_EU | B_LA);
                    4'b0010: c = (step == 4) ? (B_EI | B_LM) : (step == 5) ? (B_CE | B_LB) : (B_SU | B_EU | B_LA);
                    4'b1110: c = (step == 4) ? (B_EA | B_LO) : 16'h0;
`ifdef SAP_JUMP_EN
                    4'b0011: c = (step == 4) ? (B_EI | B_JP) : 16'h0;
`endif
                    default: c = 16'h0;
                endcase
            end
        end
        return c;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one clock, advance the model, then check 1 ns after the edge.
    task automatic cycle(input logic clr, input logic [3:0] op, input string tag);
        logic [15:0] drivers;
        clear      = clr;
        bus.opcode = op;
        @(posedge clk);
        if (!clr) begin
            m_step   = 1;
            m_halted = 1'b0;
        end else if (!m_halted) begin
            if (m_step == 4 && op == 4'b1111) m_halted = 1'b1;
            else m_step = (m_step % 6) + 1;
        end
        #1;
        check({tag, ".t_state"}, {10'h0, bus.t_state},
              m_halted ? 16'h0 : (16'h1 << (m_step - 1)));
        check({tag, ".halted"}, {15'h0, bus.halted}, {15'h0, m_halted});
        check({tag, ".con"}, {3'h0, bus.con}, exp_con(op, m_step, m_halted));
        drivers = {3'h0, bus.con} & (B_EP | B_CE | B_EI | B_EA | B_EU);
        check({tag, ".one_driver"}, {15'h0, ($countones(drivers) <= 1)}, 16'h1);
    endtask

    task automatic run_instr(input logic [3:0] op, input string tag);
        for (int i = 0; i < 6; i++) cycle(1'b1, op, tag);
    endtask

    initial begin
        logic [3:0] rop;
        logic       rclr;
        vectors     = 0;
        miscompares = 0;
        m_step      = 1;
        m_halted    = 1'b0;
        clear       = 1'b0;
        bus.opcode  = 4'b0000;

        // Reset state
        cycle(1'b0, 4'b0000, "reset");

        // LDA free-run across the wrap
        run_instr(4'b0000, "lda");
        cycle(1'b1, 4'b0000, "lda_wrap");
        cycle(1'b0, 4'b0000, "reset2");

        run_instr(4'b0001, "add");
        run_instr(4'b0010, "sub");
        run_instr(4'b1110, "out");
        run_instr(4'b0101, "undef");
        run_instr(4'b0011, "jmp");

        // HLT: halt at end of T4, hold frozen, then clear
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'b1111, "hlt");
        for (int i = 0; i < 20; i++) cycle(1'b1, 4'b1111, "halted_hold");
        cycle(1'b0, 4'b1111, "halt_clear");

        // Clear in T5 of ADD
        for (int i = 0; i < 4; i++) cycle(1'b1, 4'b0001, "add_pre");
        cycle(1'b0, 4'b0001, "mid_clear");
        cycle(1'b1, 4'b0001, "after_mid_clear");

        // Randomized: opcode changes only at T1 so it is stable from T4 on
        rop = 4'b0000;
        for (int i = 0; i < 400; i++) begin
            if (m_halted || m_step == 6) rop = 4'($urandom_range(0, 15));
            rclr = ($urandom_range(0, 24) != 0);
            if (m_halted && $urandom_range(0, 5) == 0) rclr = 1'b0;
            cycle(rclr, rop, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
